// File: rtl/periph_bus_if.sv
// CPU memory port, slave port fan-out and error status bundled for periph_bus_ctrl.
// master: CPU plus slave environment; slave: the bus controller.
interface periph_bus_if #(
   parameter int NUM_SLAVES = 8
);
   logic [31:0]              mem_addr;
   logic [31:0]              mem_wdata;
   logic [3:0]               mem_wmask;
   logic                     mem_rstrb;
   logic [31:0]              mem_rdata;
   logic                     mem_rbusy;
   logic                     mem_wbusy;

   logic [NUM_SLAVES-1:0]    slv_cs;
   logic [31:0]              slv_addr;
   logic [31:0]              slv_wdata;
   logic [3:0]               slv_wmask;
   logic                     slv_rd;
   logic                     slv_wr;
   logic [32*NUM_SLAVES-1:0] slv_rdata;
   logic [NUM_SLAVES-1:0]    slv_ready;

   logic                     err_pulse;
   logic [31:0]              err_addr;
   logic [7:0]               err_count;

   modport master (
      output mem_addr, mem_wdata, mem_wmask, mem_rstrb, slv_rdata, slv_ready,
      input  mem_rdata, mem_rbusy, mem_wbusy, slv_cs, slv_addr, slv_wdata,
             slv_wmask, slv_rd, slv_wr, err_pulse, err_addr, err_count
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_wmask, mem_rstrb, slv_rdata, slv_ready,
      output mem_rdata, mem_rbusy, mem_wbusy, slv_cs, slv_addr, slv_wdata,
             slv_wmask, slv_rd, slv_wr, err_pulse, err_addr, err_count
   );
endinterface

// File: rtl/periph_bus_ctrl.sv
// Page-decoded peripheral bus controller with wait states and error reporting.
// Optional wait-state timeout enabled by defining PERIPH_BUS_TIMEOUT_EN.
module periph_bus_ctrl #(
   parameter int          NUM_SLAVES     = 8,
   parameter logic [15:0] PAGE_BASE      = 16'h0040,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
   input logic         clk,
   input logic         reset,
   periph_bus_if.slave bus
);
   if (NUM_SLAVES < 2 || NUM_SLAVES > 16) begin : g_bad_slaves
      $error("NUM_SLAVES out of range 2..16");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES out of range 1..65535");
   end

   typedef enum logic {IDLE, WAIT} state_t;
   state_t state_q, state_d;

   logic [31:0]           addr_q, wdata_q, rdata_q, err_addr_q;
   logic [3:0]            wmask_q;
   logic [NUM_SLAVES-1:0] sel_q, sel_dec;
   logic                  is_write_q, err_pulse_q;
   logic [7:0]            err_count_q;

   logic                  start, done, err, ready_sel, unmapped, timeout;
   logic [31:0]           rdata_mux;
   logic [15:0]           page;

   // Page 0 wins over the PAGE_BASE window so the select stays one-hot.
   always_comb begin
      sel_dec = '0;
      page    = bus.mem_addr[31:16];
      if (page == 16'h0000) begin
         sel_dec[0] = 1'b1;
      end else begin
         for (int i = 1; i < NUM_SLAVES; i++) begin
            if (page == PAGE_BASE + 16'(i - 1)) sel_dec[i] = 1'b1;
         end
      end
   end

   always_comb begin
      rdata_mux = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (sel_q[i]) rdata_mux = bus.slv_rdata[32*i +: 32];
      end
   end

   assign ready_sel = |(bus.slv_ready & sel_q);
   assign unmapped  = ~|sel_q;

`ifdef PERIPH_BUS_TIMEOUT_EN
   logic [15:0] wait_cnt_q;

   always_ff @(posedge clk) begin
      if (reset || state_q == IDLE) wait_cnt_q <= '0;
      else                          wait_cnt_q <= wait_cnt_q + 16'd1;
   end

   // Fires in the TIMEOUT_CYCLES-th WAIT cycle, giving exactly that many busy cycles.
   assign timeout = ({1'b0, wait_cnt_q} + 17'd1) == 17'(TIMEOUT_CYCLES);
`else
   assign timeout = 1'b0;
`endif

   // NOTE: every output of this block is defaulted first so no latch is inferred.
   always_comb begin
      state_d       = state_q;
      start         = 1'b0;
      done          = 1'b0;
      err           = 1'b0;
      bus.slv_cs    = '0;
      bus.slv_addr  = '0;
      bus.slv_wdata = '0;
      bus.slv_wmask = '0;
      bus.slv_rd    = 1'b0;
      bus.slv_wr    = 1'b0;
      bus.mem_rbusy = 1'b0;
      bus.mem_wbusy = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.mem_rstrb || (|bus.mem_wmask)) begin
               start   = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            bus.slv_cs    = sel_q;
            bus.slv_addr  = addr_q;
            bus.slv_wdata = wdata_q;
            bus.slv_wmask = wmask_q;
            bus.slv_rd    = ~is_write_q;
            bus.slv_wr    = is_write_q;
            bus.mem_rbusy = ~is_write_q;
            bus.mem_wbusy = is_write_q;
            if (unmapped) begin
               err  = 1'b1;
               done = 1'b1;
            end else if (ready_sel) begin
               done = 1'b1;
            end else if (timeout) begin
               err  = 1'b1;
               done = 1'b1;
            end
            if (done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wmask_q     <= '0;
         sel_q       <= '0;
         is_write_q  <= 1'b0;
         rdata_q     <= '0;
         err_pulse_q <= 1'b0;
         err_addr_q  <= '0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         err_pulse_q <= err;
         if (start) begin
            addr_q     <= bus.mem_addr;
            wdata_q    <= bus.mem_wdata;
            wmask_q    <= bus.mem_wmask;
            sel_q      <= sel_dec;
            is_write_q <= |bus.mem_wmask;
         end
         if (done && !is_write_q) rdata_q <= err ? ERR_DATA : rdata_mux;
         if (err) begin
            err_addr_q <= addr_q;
            if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
         end
      end
   end

   assign bus.mem_rdata = rdata_q;
   assign bus.err_pulse = err_pulse_q;
   assign bus.err_addr  = err_addr_q;
   assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Directed self-checking bench for periph_bus_ctrl; samples and drives on the falling edge.
module tb_periph_bus_ctrl;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   periph_bus_if #(.NUM_SLAVES(8)) bus ();

   periph_bus_ctrl #(.NUM_SLAVES(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_wmask = '0;
      bus.mem_rstrb = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      bus.slv_ready = '1;
      for (int i = 0; i < 8; i++) bus.slv_rdata[32*i +: 32] = 32'hC0DE0000 | 32'(i);
      bus.slv_rdata[31:0] = 32'h12345678;
      repeat (2) @(negedge clk);
      total++; if (bus.mem_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", bus.mem_rdata); end
      total++; if ({bus.mem_rbusy, bus.mem_wbusy, bus.slv_rd, bus.slv_wr} !== 4'b0) begin bad++; $display("FAIL reset_flags: got %b want 0000", {bus.mem_rbusy, bus.mem_wbusy, bus.slv_rd, bus.slv_wr}); end
      total++; if (bus.slv_cs !== 8'h0 || bus.slv_addr !== 32'h0 || bus.slv_wdata !== 32'h0 || bus.slv_wmask !== 4'h0) begin bad++; $display("FAIL reset_slv: cs=%h addr=%h wdata=%h wmask=%h want 0", bus.slv_cs, bus.slv_addr, bus.slv_wdata, bus.slv_wmask); end
      total++; if (bus.err_pulse !== 1'b0 || bus.err_addr !== 32'h0 || bus.err_count !== 8'h0) begin bad++; $display("FAIL reset_err: pulse=%b addr=%h count=%0d want 0", bus.err_pulse, bus.err_addr, bus.err_count); end
      reset = 1'b0;
   endtask

   task automatic test_read_slave0();
      bus.mem_addr  = 32'h0000_0010;
      bus.mem_rstrb = 1'b1;
      @(negedge clk);
      total++; if (bus.mem_rbusy !== 1'b1 || bus.mem_wbusy !== 1'b0) begin bad++; $display("FAIL rd0_busy: rbusy=%b wbusy=%b want 1 0", bus.mem_rbusy, bus.mem_wbusy); end
      total++; if (bus.slv_cs !== 8'h01 || bus.slv_rd !== 1'b1 || bus.slv_addr !== 32'h10) begin bad++; $display("FAIL rd0_slv: cs=%h rd=%b addr=%h want 01 1 00000010", bus.slv_cs, bus.slv_rd, bus.slv_addr); end
      idle_inputs();
      @(negedge clk);
      total++; if (bus.mem_rbusy !== 1'b0 || bus.slv_cs !== 8'h0) begin bad++; $display("FAIL rd0_done: rbusy=%b cs=%h want 0 00", bus.mem_rbusy, bus.slv_cs); end
      total++; if (bus.mem_rdata !== 32'h12345678) begin bad++; $display("FAIL rd0_data: got %h want 12345678", bus.mem_rdata); end
      total++; if (bus.err_pulse !== 1'b0) begin bad++; $display("FAIL rd0_noerr: got %b want 0", bus.err_pulse); end
   endtask

   task automatic test_write_wait();
      bus.slv_ready[3] = 1'b0;
      bus.mem_addr     = 32'h0042_0004;
      bus.mem_wdata    = 32'h0000_00A5;
      bus.mem_wmask    = 4'hF;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         if (c == 1) idle_inputs();
         if (c == 3) bus.slv_ready[3] = 1'b1;
         total++; if (bus.mem_wbusy !== 1'b1 || bus.mem_rbusy !== 1'b0) begin bad++; $display("FAIL wr3_busy c%0d: wbusy=%b rbusy=%b want 1 0", c, bus.mem_wbusy, bus.mem_rbusy); end
         total++; if (bus.slv_cs !== 8'b0000_1000 || bus.slv_wr !== 1'b1 || bus.slv_wdata !== 32'hA5 || bus.slv_wmask !== 4'hF || bus.slv_addr !== 32'h0042_0004) begin bad++; $display("FAIL wr3_slv c%0d: cs=%b wr=%b wdata=%h wmask=%h addr=%h", c, bus.slv_cs, bus.slv_wr, bus.slv_wdata, bus.slv_wmask, bus.slv_addr); end
      end
      @(negedge clk);
      total++; if (bus.mem_wbusy !== 1'b0 || bus.slv_wr !== 1'b0) begin bad++; $display("FAIL wr3_done: wbusy=%b wr=%b want 0 0", bus.mem_wbusy, bus.slv_wr); end
      total++; if (bus.mem_rdata !== 32'h12345678) begin bad++; $display("FAIL wr3_rdata: got %h want 12345678", bus.mem_rdata); end
   endtask

   task automatic test_unmapped_read();
      bus.mem_addr  = 32'h00FF_0000;
      bus.mem_rstrb = 1'b1;
      @(negedge clk);
      idle_inputs();
      total++; if (bus.mem_rbusy !== 1'b1 || bus.slv_cs !== 8'h0) begin bad++; $display("FAIL unm_wait: rbusy=%b cs=%h want 1 00", bus.mem_rbusy, bus.slv_cs); end
      @(negedge clk);
      total++; if (bus.mem_rbusy !== 1'b0 || bus.mem_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL unm_data: rbusy=%b rdata=%h want 0 deadbeef", bus.mem_rbusy, bus.mem_rdata); end
      total++; if (bus.err_pulse !== 1'b1 || bus.err_addr !== 32'h00FF_0000 || bus.err_count !== 8'd1) begin bad++; $display("FAIL unm_err: pulse=%b addr=%h count=%0d want 1 00ff0000 1", bus.err_pulse, bus.err_addr, bus.err_count); end
      @(negedge clk);
      total++; if (bus.err_pulse !== 1'b0) begin bad++; $display("FAIL unm_pulse_len: got %b want 0", bus.err_pulse); end
   endtask

   task automatic test_ignore_during_wait();
      bus.slv_ready = 8'hFB;
      bus.mem_addr  = 32'h0041_0008;
      bus.mem_rstrb = 1'b1;
      @(negedge clk);
      bus.mem_wmask = 4'hF;
      bus.mem_addr  = 32'h0000_0000;
      total++; if (bus.slv_cs !== 8'h04 || bus.mem_rbusy !== 1'b1) begin bad++; $display("FAIL ign_sel: cs=%h rbusy=%b want 04 1", bus.slv_cs, bus.mem_rbusy); end
      @(negedge clk);
      total++; if (bus.mem_rbusy !== 1'b1 || bus.mem_wbusy !== 1'b0 || bus.slv_wmask !== 4'h0 || bus.slv_addr !== 32'h0041_0008) begin bad++; $display("FAIL ign_hold: rbusy=%b wbusy=%b wmask=%h addr=%h", bus.mem_rbusy, bus.mem_wbusy, bus.slv_wmask, bus.slv_addr); end
      idle_inputs();
      bus.slv_ready = 8'hFF;
      @(negedge clk);
      total++; if (bus.mem_rbusy !== 1'b0 || bus.mem_rdata !== 32'hC0DE0002) begin bad++; $display("FAIL ign_data: rbusy=%b rdata=%h want 0 c0de0002", bus.mem_rbusy, bus.mem_rdata); end
   endtask

   task automatic test_read_write_collision();
      bus.mem_addr  = 32'h0000_0020;
      bus.mem_rstrb = 1'b1;
      bus.mem_wmask = 4'h3;
      @(negedge clk);
      idle_inputs();
      total++; if (bus.mem_wbusy !== 1'b1 || bus.mem_rbusy !== 1'b0 || bus.slv_wr !== 1'b1 || bus.slv_rd !== 1'b0) begin bad++; $display("FAIL rw_dir: wbusy=%b rbusy=%b wr=%b rd=%b want 1 0 1 0", bus.mem_wbusy, bus.mem_rbusy, bus.slv_wr, bus.slv_rd); end
      @(negedge clk);
      total++; if (bus.mem_wbusy !== 1'b0 || bus.mem_rdata !== 32'hC0DE0002) begin bad++; $display("FAIL rw_done: wbusy=%b rdata=%h want 0 c0de0002", bus.mem_wbusy, bus.mem_rdata); end
   endtask

   task automatic test_timeout();
      int cycles;
      bus.slv_rdata[64 +: 32] = 32'hBEEF0002;
      bus.slv_ready[2] = 1'b0;
      bus.mem_addr     = 32'h0041_0000;
      bus.mem_rstrb    = 1'b1;
      @(negedge clk);
      idle_inputs();
`ifdef PERIPH_BUS_TIMEOUT_EN
      cycles = 0;
      while (bus.mem_rbusy === 1'b1 && cycles < 400) begin
         cycles++;
         @(negedge clk);
      end
      total++; if (cycles != 255) begin bad++; $display("FAIL to_cycles: got %0d want 255", cycles); end
      total++; if (bus.mem_rdata !== 32'hDEADBEEF || bus.err_count !== 8'd2 || bus.err_pulse !== 1'b1) begin bad++; $display("FAIL to_err: rdata=%h count=%0d pulse=%b want deadbeef 2 1", bus.mem_rdata, bus.err_count, bus.err_pulse); end
`else
      cycles = 0;
      repeat (300) begin
         @(negedge clk);
         if (bus.mem_rbusy === 1'b1) cycles++;
      end
      total++; if (cycles != 300) begin bad++; $display("FAIL to_hold: busy cycles %0d want 300", cycles); end
      bus.slv_ready[2] = 1'b1;
      @(negedge clk);
      total++; if (bus.mem_rbusy !== 1'b0 || bus.mem_rdata !== 32'hBEEF0002 || bus.err_count !== 8'd1) begin bad++; $display("FAIL to_ready: rbusy=%b rdata=%h count=%0d want 0 beef0002 1", bus.mem_rbusy, bus.mem_rdata, bus.err_count); end
`endif
      bus.slv_ready = 8'hFF;
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      bus.slv_ready[1] = 1'b0;
      bus.mem_addr     = 32'h0040_0000;
      bus.mem_wmask    = 4'h1;
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      total++; if (bus.mem_wbusy !== 1'b1 || bus.slv_cs !== 8'h02) begin bad++; $display("FAIL abort_pre: wbusy=%b cs=%h want 1 02", bus.mem_wbusy, bus.slv_cs); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      total++; if (bus.mem_wbusy !== 1'b0 || bus.mem_rbusy !== 1'b0 || bus.slv_cs !== 8'h0 || bus.err_count !== 8'd0) begin bad++; $display("FAIL abort_post: wbusy=%b rbusy=%b cs=%h count=%0d want 0 0 00 0", bus.mem_wbusy, bus.mem_rbusy, bus.slv_cs, bus.err_count); end
      @(negedge clk);
      total++; if (bus.err_pulse !== 1'b0 || bus.mem_wbusy !== 1'b0) begin bad++; $display("FAIL abort_quiet: pulse=%b wbusy=%b want 0 0", bus.err_pulse, bus.mem_wbusy); end
      bus.slv_ready = 8'hFF;
   endtask

   task automatic test_saturate();
      for (int n = 1; n <= 257; n++) begin
         if (n == 255) begin
            total++; if (bus.err_count !== 8'd254) begin bad++; $display("FAIL sat_254: got %0d want 254", bus.err_count); end
         end
         bus.mem_addr  = 32'hFFFF_0000;
         bus.mem_wmask = 4'h8;
         @(negedge clk);
         idle_inputs();
         @(negedge clk);
         if (n == 256) begin
            total++; if (bus.err_count !== 8'd255) begin bad++; $display("FAIL sat_255: got %0d want 255", bus.err_count); end
         end
      end
      total++; if (bus.err_count !== 8'd255 || bus.err_addr !== 32'hFFFF_0000) begin bad++; $display("FAIL sat_hold: count=%0d addr=%h want 255 ffff0000", bus.err_count, bus.err_addr); end
   endtask

   initial begin
      test_reset();
      test_read_slave0();
      test_write_wait();
      test_unmapped_read();
      test_ignore_during_wait();
      test_read_write_collision();
      test_timeout();
      test_reset_abort();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
